// File: rtl/multi_core_cmd_loader_if.sv
// Word-stream load port of the command loader: one MEM_WIDTH word per handshake,
// with burst-open marker and the core/address fields sampled on the opening word.
interface multi_core_cmd_loader_if #(
    parameter int MEM_WIDTH      = 32,
    parameter int CORE_ID_WIDTH  = 2,
    parameter int CMD_ADDR_WIDTH = 16
) ();
    logic                      valid;
    logic                      ready;
    logic [MEM_WIDTH-1:0]      data;
    logic                      first;
    logic [CORE_ID_WIDTH-1:0]  core;
    logic [CMD_ADDR_WIDTH-1:0] addr;

    modport master (output valid, data, first, core, addr, input ready);
    modport slave  (input valid, data, first, core, addr, output ready);
endinterface

// File: rtl/multi_core_cmd_loader.sv
// Assembles WORDS_PER_CMD stream words into one command and writes it to the
// selected core's command memory at consecutive addresses within a burst.
module multi_core_cmd_loader #(
    parameter int N_CORES        = 4,
    parameter int CORE_ID_WIDTH  = 2,
    parameter int MEM_WIDTH      = 32,
    parameter int WORDS_PER_CMD  = 4,
    parameter int CMD_ADDR_WIDTH = 16,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    multi_core_cmd_loader_if.slave               s,
    input  logic                                 err_clear,
    output logic [WORDS_PER_CMD*MEM_WIDTH-1:0]   cmd_write,
    output logic [CMD_ADDR_WIDTH-1:0]            cmd_write_addr,
    output logic [N_CORES-1:0]                   cmd_write_enable,
    output logic                                 load_busy,
    output logic                                 err_sticky,
    output logic [COUNT_WIDTH-1:0]               cmd_count
);
    localparam int IDX_W = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;
    localparam int CMD_W = WORDS_PER_CMD * MEM_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    state_t                    state_r;
    logic [IDX_W-1:0]          idx_r;
    logic [CORE_ID_WIDTH-1:0]  core_r;
    logic [CMD_ADDR_WIDTH-1:0] addr_r;
    logic [CMD_W-1:0]          cmd_buf_r;
    logic [CMD_W-1:0]          cmd_write_r;
    logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr_r;
    logic [N_CORES-1:0]        cmd_write_enable_r;
    logic                      load_busy_r;
    logic                      err_sticky_r;
    logic [COUNT_WIDTH-1:0]    cmd_count_r;

    logic                      s_ready_s;
    logic                      accept_s;
    logic                      store_s;
    logic                      last_s;
    logic                      core_ok_s;
    logic                      err_set_s;
    logic [IDX_W-1:0]          wr_idx_s;
    logic [CORE_ID_WIDTH-1:0]  core_sel_s;
    logic [CMD_ADDR_WIDTH-1:0] addr_sel_s;
    logic [CMD_W-1:0]          assembled_s;
    logic [N_CORES-1:0]        core_onehot_s;

    // The only bubble is the commit cycle; reset blocks acceptance immediately.
    assign s_ready_s = reset && (state_r != COMMIT);
    assign accept_s  = s.valid && s_ready_s;
    assign store_s   = accept_s && (s.first || (state_r == ASSEMBLE));
    assign last_s    = (wr_idx_s == IDX_W'(WORDS_PER_CMD - 1));
    assign core_ok_s = |core_onehot_s;

    // Select the chunk slot, core and base address the incoming word belongs to.
    always_comb begin
        if (s.first) begin
            wr_idx_s   = '0;
            core_sel_s = s.core;
            addr_sel_s = s.addr;
        end else begin
            wr_idx_s   = idx_r;
            core_sel_s = core_r;
            addr_sel_s = addr_r;
        end
        assembled_s = cmd_buf_r;
        assembled_s[int'(wr_idx_s) * MEM_WIDTH +: MEM_WIDTH] = s.data;
    end

    // Out-of-range core ids decode to no strobe at all.
    always_comb begin
        core_onehot_s = '0;
        for (int i = 0; i < N_CORES; i++) begin
            core_onehot_s[i] = (core_sel_s == CORE_ID_WIDTH'(i));
        end
    end

    // Protocol errors: discarded partial, orphan word in IDLE, commit to a missing core.
    always_comb begin
        if (accept_s && s.first && (state_r == ASSEMBLE) && (idx_r != '0)) begin
            err_set_s = 1'b1;
        end else if (accept_s && !s.first && (state_r == IDLE)) begin
            err_set_s = 1'b1;
        end else if (store_s && last_s && !core_ok_s) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Burst FSM with registered command, strobe, status and counter outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r            <= IDLE;
            idx_r              <= '0;
            core_r             <= '0;
            addr_r             <= '0;
            cmd_buf_r          <= '0;
            cmd_write_r        <= '0;
            cmd_write_addr_r   <= '0;
            cmd_write_enable_r <= '0;
            load_busy_r        <= 1'b0;
            err_sticky_r       <= 1'b0;
            cmd_count_r        <= '0;
        end else begin
            cmd_write_enable_r <= '0;
            if (err_set_s) begin
                err_sticky_r <= 1'b1;
            end else if (err_clear) begin
                err_sticky_r <= 1'b0;
            end else begin
                err_sticky_r <= err_sticky_r;
            end

            case (state_r)
                IDLE, ASSEMBLE: begin
                    if (store_s) begin
                        core_r    <= core_sel_s;
                        addr_r    <= addr_sel_s;
                        cmd_buf_r <= assembled_s;
                        if (last_s) begin
                            state_r            <= COMMIT;
                            idx_r              <= '0;
                            load_busy_r        <= 1'b0;
                            cmd_write_r        <= assembled_s;
                            cmd_write_addr_r   <= addr_sel_s;
                            cmd_write_enable_r <= core_onehot_s;
                            if (core_ok_s) begin
                                cmd_count_r <= cmd_count_r + COUNT_WIDTH'(1);
                            end else begin
                                cmd_count_r <= cmd_count_r;
                            end
                        end else begin
                            state_r     <= ASSEMBLE;
                            idx_r       <= wr_idx_s + IDX_W'(1);
                            load_busy_r <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                COMMIT: begin
                    state_r     <= ASSEMBLE;
                    idx_r       <= '0;
                    addr_r      <= addr_r + CMD_ADDR_WIDTH'(1);
                    load_busy_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    idx_r       <= '0;
                    load_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign s.ready          = s_ready_s;
    assign cmd_write        = cmd_write_r;
    assign cmd_write_addr   = cmd_write_addr_r;
    assign cmd_write_enable = cmd_write_enable_r;
    assign load_busy        = load_busy_r;
    assign err_sticky       = err_sticky_r;
    assign cmd_count        = cmd_count_r;
endmodule

// File: tb/tb_multi_core_cmd_loader.sv
// Directed bench for multi_core_cmd_loader: a 4-core build and a 3-core build
// share one stimulus driver; expected values are hand-computed constants.
module tb_multi_core_cmd_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic err_clear = 1'b0;
    always #5 clk = ~clk;

    logic        drv_valid = 1'b0;
    logic        drv_first = 1'b0;
    logic [1:0]  drv_core  = 2'd0;
    logic [15:0] drv_addr  = 16'd0;
    logic [31:0] drv_data  = 32'd0;
    logic        use3      = 1'b0;

    multi_core_cmd_loader_if #(.MEM_WIDTH(32), .CORE_ID_WIDTH(2), .CMD_ADDR_WIDTH(16)) bus ();
    multi_core_cmd_loader_if #(.MEM_WIDTH(32), .CORE_ID_WIDTH(2), .CMD_ADDR_WIDTH(16)) bus3 ();

    assign bus.valid  = drv_valid & ~use3;
    assign bus.first  = drv_first;
    assign bus.core   = drv_core;
    assign bus.addr   = drv_addr;
    assign bus.data   = drv_data;
    assign bus3.valid = drv_valid & use3;
    assign bus3.first = drv_first;
    assign bus3.core  = drv_core;
    assign bus3.addr  = drv_addr;
    assign bus3.data  = drv_data;

    logic [127:0] cmd_write,  cmd_write3;
    logic [15:0]  cmd_addr,   cmd_addr3;
    logic [3:0]   en;
    logic [2:0]   en3;
    logic         busy, busy3, err, err3;
    logic [31:0]  count, count3;

    multi_core_cmd_loader #(.N_CORES(4)) dut (
        .clk(clk), .reset(reset), .s(bus), .err_clear(err_clear),
        .cmd_write(cmd_write), .cmd_write_addr(cmd_addr), .cmd_write_enable(en),
        .load_busy(busy), .err_sticky(err), .cmd_count(count)
    );

    multi_core_cmd_loader #(.N_CORES(3)) dut3 (
        .clk(clk), .reset(reset), .s(bus3), .err_clear(err_clear),
        .cmd_write(cmd_write3), .cmd_write_addr(cmd_addr3), .cmd_write_enable(en3),
        .load_busy(busy3), .err_sticky(err3), .cmd_count(count3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    // Counts write strobes of the 4-core build, one per cycle the enable is high.
    always @(negedge clk) begin
        if (|en) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drv_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Present one word and return at the negedge following its accepting edge.
    task automatic send_word(input logic first, input logic [1:0] core,
                             input logic [15:0] addr, input logic [31:0] data);
        int n;
        logic rdy;
        drv_first = first;
        drv_core  = core;
        drv_addr  = addr;
        drv_data  = data;
        drv_valid = 1'b1;
        n = 0;
        rdy = use3 ? bus3.ready : bus.ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            rdy = use3 ? bus3.ready : bus.ready;
        end
        if (!rdy) check("ready_timeout", 128'(rdy), 128'd1);
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_first = 1'b0;
    endtask

    initial begin
        // Reset values while reset is held low
        #12;
        check("rst_ready",  128'(bus.ready), 128'd0);
        check("rst_en",     128'(en), 128'd0);
        check("rst_cmd",    cmd_write, 128'd0);
        check("rst_addr",   128'(cmd_addr), 128'd0);
        check("rst_cnt",    128'(count), 128'd0);
        check("rst_err",    128'(err), 128'd0);
        check("rst_busy",   128'(busy), 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single command to core 1
        send_word(1'b1, 2'd1, 16'h0010, 32'h11111111);
        send_word(1'b0, 2'd0, 16'h0000, 32'h22222222);
        check("t1_busy", 128'(busy), 128'd1);
        send_word(1'b0, 2'd0, 16'h0000, 32'h33333333);
        send_word(1'b0, 2'd0, 16'h0000, 32'h44444444);
        check("t1_en",    128'(en), 128'h2);
        check("t1_addr",  128'(cmd_addr), 128'h0010);
        check("t1_cmd",   cmd_write, 128'h44444444_33333333_22222222_11111111);
        check("t1_cnt",   128'(count), 128'd1);
        check("t1_ready", 128'(bus.ready), 128'd0);
        @(negedge clk);
        check("t1_en_off", 128'(en), 128'h0);
        check("t1_ready2", 128'(bus.ready), 128'd1);
        check("t1_cmd_hold", cmd_write, 128'h44444444_33333333_22222222_11111111);

        // Continuous 8-word burst, address wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_word(i == 0, 2'd3, 16'hFFFF, 32'hA0000000 + 32'(i));
            if (i == 3) begin
                check("t2_en0",   128'(en), 128'h8);
                check("t2_addr0", 128'(cmd_addr), 128'hFFFF);
                check("t2_cmd0",  cmd_write, 128'hA0000003_A0000002_A0000001_A0000000);
            end
            if (i == 7) begin
                check("t2_en1",   128'(en), 128'h8);
                check("t2_addr1", 128'(cmd_addr), 128'h0000);
                check("t2_cmd1",  cmd_write, 128'hA0000007_A0000006_A0000005_A0000004);
                check("t2_cnt",   128'(count), 128'd2);
            end
        end

        // Partial command discarded by a new first word
        do_reset();
        @(negedge clk);
        pulses = 0;
        send_word(1'b1, 2'd2, 16'h0020, 32'hC0000000);
        send_word(1'b0, 2'd0, 16'h0000, 32'hC0000001);
        send_word(1'b0, 2'd0, 16'h0000, 32'hC0000002);
        check("t3_err_pre", 128'(err), 128'd0);
        send_word(1'b1, 2'd0, 16'h0005, 32'hB0000000);
        check("t3_err",     128'(err), 128'd1);
        check("t3_busy",    128'(busy), 128'd1);
        send_word(1'b0, 2'd0, 16'h0000, 32'hB0000001);
        send_word(1'b0, 2'd0, 16'h0000, 32'hB0000002);
        check("t3_nowrite", 128'(pulses), 128'd0);
        send_word(1'b0, 2'd0, 16'h0000, 32'hB0000003);
        check("t3_en",   128'(en), 128'h1);
        check("t3_addr", 128'(cmd_addr), 128'h0005);
        check("t3_cmd",  cmd_write, 128'hB0000003_B0000002_B0000001_B0000000);
        check("t3_cnt",  128'(count), 128'd1);
        @(negedge clk);
        check("t3_pulses", 128'(pulses), 128'd1);

        // Orphan word in IDLE, err_clear, and set-beats-clear
        do_reset();
        send_word(1'b0, 2'd1, 16'h0003, 32'hDEADBEEF);
        check("t4_err",   128'(err), 128'd1);
        check("t4_busy",  128'(busy), 128'd0);
        check("t4_ready", 128'(bus.ready), 128'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("t4_clr", 128'(err), 128'd0);
        err_clear = 1'b1;
        send_word(1'b0, 2'd1, 16'h0003, 32'hDEADBEEF);
        err_clear = 1'b0;
        check("t4_setwins", 128'(err), 128'd1);

        // 3-core build addressed with core id 3
        do_reset();
        use3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(i == 0, 2'd3, 16'h0007, 32'hE0000000 + 32'(i));
        end
        check("t5_ready", 128'(bus3.ready), 128'd0);
        check("t5_en",    128'(en3), 128'h0);
        check("t5_cnt",   128'(count3), 128'd0);
        check("t5_err",   128'(err3), 128'd1);
        check("t5_other", 128'(count), 128'd0);
        use3 = 1'b0;

        // Reset during the commit cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_word(i == 0, 2'd2, 16'h0009, 32'hF0000000 + 32'(i));
        end
        check("t6_en", 128'(en), 128'h4);
        #1;
        reset = 1'b0;
        #1;
        check("t6_en_async", 128'(en), 128'h0);
        check("t6_ready",    128'(bus.ready), 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_cnt",  128'(count), 128'd0);
        check("t6_busy", 128'(busy), 128'd0);
        check("t6_en_after", 128'(en), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
